// File: rtl/ps2_kbd_matrix_if.sv
// Byte-level link between the PS/2 transceiver and the keyboard front-end.
// master = keyboard front-end, slave = transceiver.
interface ps2_kbd_matrix_if;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       rx_err;
   logic [7:0] tx_byte;
   logic       tx_start;
   logic       tx_busy;

   modport master (
      input  rx_byte,
      input  rx_valid,
      input  rx_err,
      input  tx_busy,
      output tx_byte,
      output tx_start
   );

   modport slave (
      output rx_byte,
      output rx_valid,
      output rx_err,
      output tx_busy,
      input  tx_byte,
      input  tx_start
   );
endinterface

// File: rtl/ps2_kbd_matrix.sv
// PS/2 scancode decoder to active-low key matrix, plus LED command
// sequencer (0xED + mask) with ACK, resend and timeout handling.
module ps2_kbd_matrix #(
   parameter int CLK_FREQ   = 28000000,
   parameter int ROWS       = 8,
   parameter int COLS       = 5,
   parameter int ACK_TMO_US = 20000,
   parameter int RETRIES    = 3
) (
   input  logic                    clk,
   input  logic                    rst_n,
   ps2_kbd_matrix_if.master        bus,
   output logic [8:0]              map_code,
   input  logic                    map_hit,
   input  logic [$clog2(ROWS)-1:0] map_row,
   input  logic [$clog2(COLS)-1:0] map_col,
   input  logic [2:0]              leds,
   input  logic [ROWS-1:0]         kb_addr,
   output logic [COLS-1:0]         kb_data,
   output logic [8:0]              key_code,
   output logic                    key_press,
   output logic                    key_strobe,
   output logic                    cmd_err
);

   localparam int TMO_CYC = CLK_FREQ / 1000000 * ACK_TMO_US;
   localparam int TW      = $clog2(TMO_CYC + 1);
   localparam int RW      = $clog2(RETRIES + 1);
   localparam int KW      = ROWS * COLS;
   localparam int IW      = $clog2(KW + 1);

   typedef enum logic [2:0] {
      D_IDLE,
      D_EXT,
      D_BRK,
      D_EXT_BRK,
      D_PAUSE
   } dstate_t;

   typedef enum logic [2:0] {
      C_IDLE,
      C_SEND_ED,
      C_WAIT1,
      C_SEND_LED,
      C_WAIT2
   } cstate_t;

   dstate_t         d_q, d_n;
   logic [2:0]      pcnt_q, pcnt_n;
   logic [KW-1:0]   key_q, key_n;
   logic [8:0]      code_n;
   logic            press_n;
   logic            strobe_n;

   cstate_t         c_q, c_n;
   logic [2:0]      lat_q, lat_n;
   logic [2:0]      sent_q, sent_n;
   logic            rp_q, rp_n;
   logic [RW-1:0]   retry_q, retry_n;
   logic [TW-1:0]   timer_q, timer_n;
   logic [7:0]      txb_n;
   logic            txs_n;
   logic            err_n;

   logic is_e0, is_e1, is_f0, is_aa;
   logic is_fa, is_fe, is_ign, is_fake;
   logic c_wait, rx_ok, rx_key, aa_evt;
   logic done, done_press;
   logic [IW-1:0] map_idx;

   assign is_e0   = bus.rx_byte == 8'hE0;
   assign is_e1   = bus.rx_byte == 8'hE1;
   assign is_f0   = bus.rx_byte == 8'hF0;
   assign is_aa   = bus.rx_byte == 8'hAA;
   assign is_fa   = bus.rx_byte == 8'hFA;
   assign is_fe   = bus.rx_byte == 8'hFE;
   assign is_ign  = is_fa || is_fe ||
                    bus.rx_byte == 8'h00 ||
                    bus.rx_byte == 8'hFF;
   assign is_fake = bus.rx_byte == 8'h12 ||
                    bus.rx_byte == 8'h59;

   assign c_wait = (c_q == C_WAIT1) || (c_q == C_WAIT2);
   assign rx_ok  = bus.rx_valid && !bus.rx_err;
   // ACK/resend bytes owned by a waiting command never reach the decoder
   assign rx_key = rx_ok && !(c_wait && (is_fa || is_fe));
   assign aa_evt = rx_ok && is_aa && (d_q == D_IDLE);

   always_comb begin
      map_code = {1'b0, bus.rx_byte};
      unique case (d_q)
         D_EXT, D_EXT_BRK: map_code = {1'b1, bus.rx_byte};
         D_PAUSE:          map_code = 9'h177;
         default:          map_code = {1'b0, bus.rx_byte};
      endcase
   end

   assign map_idx = IW'(map_row) * IW'(COLS) + IW'(map_col);

   // ---------------- decoder ----------------
   always_comb begin
      d_n        = d_q;
      pcnt_n     = pcnt_q;
      key_n      = key_q;
      code_n     = key_code;
      press_n    = key_press;
      strobe_n   = 1'b0;
      done       = 1'b0;
      done_press = 1'b0;
      if (bus.rx_valid && bus.rx_err) begin
         d_n   = D_IDLE;
         key_n = '0;
      end else if (rx_key) begin
         unique case (d_q)
            D_IDLE: begin
               unique case (1'b1)
                  is_e0: d_n = D_EXT;
                  is_f0: d_n = D_BRK;
                  is_e1: begin
                     d_n    = D_PAUSE;
                     pcnt_n = 3'd6;
                  end
                  is_aa:  key_n = '0;
                  is_ign: ;
                  default: begin
                     done       = 1'b1;
                     done_press = 1'b1;
                  end
               endcase
            end
            D_EXT: begin
               if (is_f0) begin
                  d_n = D_EXT_BRK;
               end else if (is_fake) begin
                  d_n = D_IDLE;
               end else begin
                  done       = 1'b1;
                  done_press = 1'b1;
               end
            end
            D_BRK, D_EXT_BRK: done = 1'b1;
            D_PAUSE: begin
               if (pcnt_q == 3'd0) begin
                  done       = 1'b1;
                  done_press = 1'b1;
               end else begin
                  pcnt_n = pcnt_q - 3'd1;
               end
            end
            default: d_n = D_IDLE;
         endcase
      end
      if (done) begin
         d_n      = D_IDLE;
         strobe_n = 1'b1;
         code_n   = map_code;
         press_n  = done_press;
         if (map_hit && int'(map_idx) < KW) begin
            key_n[map_idx] = done_press;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q        <= D_IDLE;
         pcnt_q     <= 3'd0;
         key_q      <= '0;
         key_code   <= 9'h000;
         key_press  <= 1'b0;
         key_strobe <= 1'b0;
      end else begin
         d_q        <= d_n;
         pcnt_q     <= pcnt_n;
         key_q      <= key_n;
         key_code   <= code_n;
         key_press  <= press_n;
         key_strobe <= strobe_n;
      end
   end

   // Any selected row holding a key pulls its column low
   always_comb begin
      kb_data = '1;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (!kb_addr[r] && key_q[r*COLS+c]) begin
               kb_data[c] = 1'b0;
            end
         end
      end
   end

   // ---------------- LED command sequencer ----------------
   always_comb begin
      c_n     = c_q;
      lat_n   = lat_q;
      sent_n  = sent_q;
      rp_n    = rp_q;
      retry_n = retry_q;
      timer_n = timer_q;
      txb_n   = bus.tx_byte;
      txs_n   = 1'b0;
      err_n   = 1'b0;
      if (aa_evt) begin
         c_n     = C_IDLE;
         rp_n    = 1'b1;
         retry_n = '0;
      end else begin
         unique case (c_q)
            C_IDLE: begin
               if ((leds != sent_q || rp_q) && !bus.tx_busy) begin
                  lat_n   = leds;
                  retry_n = '0;
                  c_n     = C_SEND_ED;
               end
            end
            C_SEND_ED, C_SEND_LED: begin
               if (!bus.tx_busy) begin
                  txb_n   = (c_q == C_SEND_ED) ? 8'hED
                                               : {5'b0, lat_q};
                  txs_n   = 1'b1;
                  timer_n = TW'(TMO_CYC);
                  c_n     = (c_q == C_SEND_ED) ? C_WAIT1 : C_WAIT2;
               end
            end
            C_WAIT1, C_WAIT2: begin
               if (rx_ok && is_fa) begin
                  if (c_q == C_WAIT1) begin
                     c_n = C_SEND_LED;
                  end else begin
                     c_n     = C_IDLE;
                     sent_n  = lat_q;
                     rp_n    = 1'b0;
                     retry_n = '0;
                  end
               end else if ((rx_ok && is_fe) || timer_q == '0) begin
                  // Give up after RETRIES; mark as sent so we do not spin
                  if (int'(retry_q) + 1 >= RETRIES) begin
                     err_n   = 1'b1;
                     c_n     = C_IDLE;
                     sent_n  = lat_q;
                     rp_n    = 1'b0;
                     retry_n = '0;
                  end else begin
                     retry_n = retry_q + RW'(1);
                     if (rx_ok && is_fe && c_q == C_WAIT2) begin
                        c_n = C_SEND_LED;
                     end else begin
                        c_n = C_SEND_ED;
                     end
                  end
               end else begin
                  timer_n = timer_q - TW'(1);
               end
            end
            default: c_n = C_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_q          <= C_IDLE;
         lat_q        <= 3'b000;
         sent_q       <= 3'b000;
         rp_q         <= 1'b1;
         retry_q      <= '0;
         timer_q      <= '0;
         bus.tx_byte  <= 8'h00;
         bus.tx_start <= 1'b0;
         cmd_err      <= 1'b0;
      end else begin
         c_q          <= c_n;
         lat_q        <= lat_n;
         sent_q       <= sent_n;
         rp_q         <= rp_n;
         retry_q      <= retry_n;
         timer_q      <= timer_n;
         bus.tx_byte  <= txb_n;
         bus.tx_start <= txs_n;
         cmd_err      <= err_n;
      end
   end

endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// Directed bench for ps2_kbd_matrix: scancode decode, matrix readout,
// LED command handshake with ACK, resend, timeout and abort.
module tb_ps2_kbd_matrix;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [8:0] map_code;
   logic       map_hit;
   logic [2:0] map_row;
   logic [2:0] map_col;
   logic [2:0] leds;
   logic [7:0] kb_addr;
   logic [4:0] kb_data;
   logic [8:0] key_code;
   logic       key_press;
   logic       key_strobe;
   logic       cmd_err;

   int chk_cnt    = 0;
   int pass_cnt   = 0;
   int strobe_cnt = 0;
   int err_cnt    = 0;
   int s0;

   ps2_kbd_matrix_if bus ();

   ps2_kbd_matrix #(
      .CLK_FREQ  (1000000),
      .ROWS      (8),
      .COLS      (5),
      .ACK_TMO_US(20),
      .RETRIES   (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .map_code  (map_code),
      .map_hit   (map_hit),
      .map_row   (map_row),
      .map_col   (map_col),
      .leds      (leds),
      .kb_addr   (kb_addr),
      .kb_data   (kb_data),
      .key_code  (key_code),
      .key_press (key_press),
      .key_strobe(key_strobe),
      .cmd_err   (cmd_err)
   );

   always #5 clk = ~clk;

   always_comb begin
      map_hit = 1'b0;
      map_row = 3'd0;
      map_col = 3'd0;
      case (map_code)
         9'h01C: begin map_hit = 1'b1; map_row = 3'd1; map_col = 3'd0; end
         9'h175: begin map_hit = 1'b1; map_row = 3'd4; map_col = 3'd3; end
         default: ;
      endcase
   end

   always @(negedge clk) begin
      if (key_strobe) strobe_cnt++;
      if (cmd_err) err_cnt++;
   end

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic send(logic [7:0] b);
      bus.rx_byte  = b;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic send_err();
      bus.rx_err = 1'b1;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_err = 1'b0;
      bus.rx_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_tx(string tag, logic [7:0] exp);
      logic [8:0] got;
      got = 9'h1FF;
      for (int i = 0; i < 60; i++) begin
         if (bus.tx_start) begin
            got = {1'b0, bus.tx_byte};
            break;
         end
         @(negedge clk);
      end
      chk(tag, 32'(got), {24'h0, exp});
      @(negedge clk);
   endtask

   task automatic no_tx(string tag);
      int n;
      n = 0;
      repeat (60) begin
         @(negedge clk);
         if (bus.tx_start) n++;
      end
      chk(tag, n, 0);
   endtask

   initial begin
      logic seen;
      rst_n        = 1'b0;
      bus.rx_byte  = 8'h00;
      bus.rx_valid = 1'b0;
      bus.rx_err   = 1'b0;
      bus.tx_busy  = 1'b0;
      leds         = 3'b000;
      kb_addr      = 8'hFD;
      repeat (3) @(negedge clk);
      chk("rst_kb_data", kb_data, 5'h1F);
      chk("rst_tx_start", bus.tx_start, 0);
      chk("rst_tx_byte", bus.tx_byte, 0);
      chk("rst_key_code", key_code, 0);
      chk("rst_strobe", {key_strobe, key_press, cmd_err}, 0);
      rst_n = 1'b1;

      wait_tx("boot_ed", 8'hED);
      send(8'hFA);
      wait_tx("boot_led", 8'h00);
      send(8'hFA);

      s0 = strobe_cnt;
      send(8'h1C);
      chk("make_1c_strobe", strobe_cnt - s0, 1);
      chk("make_1c_code", {key_press, key_code}, 10'h21C);
      chk("make_1c_data", kb_data, 5'h1E);
      kb_addr = 8'hFF;
      #1 chk("no_row_data", kb_data, 5'h1F);
      kb_addr = 8'hFD;
      send(8'hF0);
      send(8'h1C);
      chk("brk_1c_data", kb_data, 5'h1F);
      chk("brk_1c_press", key_press, 0);

      send(8'hE0);
      send(8'h75);
      chk("make_e075", {key_press, key_code}, 10'h375);
      kb_addr = 8'hEF;
      #1 chk("row4_data", kb_data, 5'h17);
      send(8'h1C);
      kb_addr = 8'hED;
      #1 chk("two_rows_or", kb_data, 5'h16);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      chk("brk_e075", {key_press, key_code}, 10'h175);
      chk("brk_e075_data", kb_data, 5'h1E);

      s0 = strobe_cnt;
      send(8'hE0);
      send(8'h12);
      chk("fake_shift", strobe_cnt - s0, 0);

      s0 = strobe_cnt;
      kb_addr = 8'h00;
      send(8'hE1);
      send(8'h14);
      send(8'h77);
      send(8'hE1);
      send(8'hF0);
      send(8'h14);
      send(8'hF0);
      send(8'h77);
      chk("pause_strobes", strobe_cnt - s0, 1);
      chk("pause_code", {key_press, key_code}, 10'h377);
      chk("pause_matrix", kb_data, 5'h1E);

      send_err();
      chk("rx_err_clear", kb_data, 5'h1F);

      kb_addr = 8'hFD;
      send(8'h1C);
      send(8'h1C);
      chk("typematic", kb_data, 5'h1E);
      send(8'hF0);
      send(8'h1C);
      chk("typematic_brk", kb_data, 5'h1F);
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      chk("brk_unpressed", kb_data, 5'h1F);

      leds = 3'b100;
      wait_tx("led4_ed", 8'hED);
      send(8'hFA);
      wait_tx("led4_mask", 8'h04);
      send(8'hFA);
      no_tx("led4_idle");

      leds = 3'b001;
      wait_tx("led1_ed", 8'hED);
      send(8'hFE);
      wait_tx("led1_ed_resend", 8'hED);
      send(8'hFA);
      wait_tx("led1_mask", 8'h01);
      send(8'hFA);

      s0 = err_cnt;
      leds = 3'b010;
      wait_tx("tmo_ed1", 8'hED);
      wait_tx("tmo_ed2", 8'hED);
      wait_tx("tmo_ed3", 8'hED);
      seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (cmd_err) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("tmo_cmd_err", seen, 1);
      no_tx("tmo_no_spin");
      chk("tmo_err_once", err_cnt - s0, 1);

      send(8'h1C);
      chk("aa_pre", kb_data, 5'h1E);
      send(8'hAA);
      kb_addr = 8'h00;
      #1 chk("aa_clear", kb_data, 5'h1F);
      wait_tx("aa_ed", 8'hED);
      send(8'hFA);
      wait_tx("aa_mask", 8'h02);
      send(8'hFA);

      send(8'h1C);
      leds = 3'b111;
      wait_tx("rst_mid_ed", 8'hED);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_kb", kb_data, 5'h1F);
      chk("rst_mid_tx", {bus.tx_start, bus.tx_byte}, 0);
      @(negedge clk);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
